// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: every pipeline-facing signal of hazard_scoreboard.
//   master : pipeline side; drives D/E/M hazard inputs and receives stall/flush/forward controls.
//   slave  : scoreboard side.
// Ports carried:
//   rsD/rtD/use_rsD/use_rtD      D-stage source operands
//   rsE/rtE/load_E/...           E-stage operands, destination, divide start
//   fwd_we/fwd_addr/fwd_ready    NUM_FWD producers, index 0 youngest
//   mem_stallM, flush_*          memory stall and redirect/exception requests
//   stall*/flush*                per-stage hold / clear
//   forward_aE/forward_bE        0 = register file, i+1 = producer i
//   div_busy/div_done            divide FSM status
interface hazard_scoreboard_if #(
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
);
  localparam int FSEL_W = $clog2(NUM_FWD + 1);

  logic [REG_AW-1:0]         rsD, rtD;
  logic                      use_rsD, use_rtD;
  logic [REG_AW-1:0]         rsE, rtE;
  logic                      load_E, reg_write_enE;
  logic [REG_AW-1:0]         reg_writeE;
  logic                      div_startE;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*REG_AW-1:0] fwd_addr;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic                      mem_stallM;
  logic                      flush_jumpE, flush_predM, flush_excM;
  logic                      stallF, stallD, stallE, stallM, stallW;
  logic                      flushF, flushD, flushE, flushM, flushW;
  logic [FSEL_W-1:0]         forward_aE, forward_bE;
  logic                      div_busy, div_done;

  modport master (
    output rsD, rtD, use_rsD, use_rtD, rsE, rtE, load_E, reg_write_enE,
           reg_writeE, div_startE, fwd_we, fwd_addr, fwd_ready, mem_stallM,
           flush_jumpE, flush_predM, flush_excM,
    input  stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW,
           forward_aE, forward_bE, div_busy, div_done
  );

  modport slave (
    input  rsD, rtD, use_rsD, use_rtD, rsE, rtE, load_E, reg_write_enE,
           reg_writeE, div_startE, fwd_we, fwd_addr, fwd_ready, mem_stallM,
           flush_jumpE, flush_predM, flush_excM,
    output stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW,
           forward_aE, forward_bE, div_busy, div_done
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard controller.
//   clk    : sole clock, rising edge
//   resetn : asynchronous active-low reset
//   hs     : hazard_scoreboard_if.slave, all hazard inputs and stall/flush/forward outputs
// Combinational forwarding / stall / flush logic plus three pieces of state:
// a cycle-counted divide occupancy FSM, and an exception latch that defers a
// flush until the memory access in M completes. Load-use is purely combinational.
module hazard_scoreboard #(
  parameter int NUM_FWD    = 2,
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 34
) (
  input  logic              clk,
  input  logic              resetn,
  hazard_scoreboard_if.slave hs
);
  localparam int FSEL_W = $clog2(NUM_FWD + 1);
  localparam int CNT_W  = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  div_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              exc_pend;

  logic [FSEL_W-1:0] sel_a, sel_b;
  logic              hit_a, hit_b, rdy_a, rdy_b;
  logic              data_stall, lu_stall;
  logic              exc_req, exc_fire;
  logic              start, div_stall, h_e, stall_e;

  // Priority forward select: scan from oldest to youngest so the youngest
  // matching producer (lowest index) is the one left standing.
  always_comb begin
    sel_a = '0; sel_b = '0;
    hit_a = 1'b0; hit_b = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hs.fwd_we[i] && hs.fwd_addr[i*REG_AW +: REG_AW] == hs.rsE && hs.rsE != '0) begin
        hit_a = 1'b1;
        sel_a = FSEL_W'(i + 1);
        rdy_a = hs.fwd_ready[i];
      end
      if (hs.fwd_we[i] && hs.fwd_addr[i*REG_AW +: REG_AW] == hs.rtE && hs.rtE != '0) begin
        hit_b = 1'b1;
        sel_b = FSEL_W'(i + 1);
        rdy_b = hs.fwd_ready[i];
      end
    end
  end

  assign data_stall = (hit_a & ~rdy_a) | (hit_b & ~rdy_b);

  assign lu_stall = hs.load_E & hs.reg_write_enE & (hs.reg_writeE != '0) &
                    ((hs.use_rsD & (hs.rsD == hs.reg_writeE)) |
                     (hs.use_rtD & (hs.rtD == hs.reg_writeE)));

  // A pending exception can only be taken once M is no longer stalled.
  assign exc_req  = hs.flush_excM | exc_pend;
  assign exc_fire = exc_req & ~hs.mem_stallM;

  assign start     = (state == IDLE) & hs.div_startE & ~exc_fire & ~hs.mem_stallM & ~data_stall;
  assign div_stall = start | (state == BUSY);
  assign h_e       = div_stall | data_stall;
  assign stall_e   = ~exc_fire & (hs.mem_stallM | h_e);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (exc_fire) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state_n = BUSY;
          cnt_n   = CNT_W'(DIV_CYCLES - 1);
        end
        // Counts through memory stalls: the divider runs regardless of M.
        BUSY: begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_n = DONE;
        end
        // Result is held until E advances; no re-arm from here.
        DONE: if (!stall_e) state_n = IDLE;
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      exc_pend <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      // Set while stalled with a request outstanding, cleared on fire.
      exc_pend <= exc_req & hs.mem_stallM;
    end
  end

  assign hs.stallF     = ~exc_fire & (hs.mem_stallM | h_e | lu_stall);
  assign hs.stallD     = hs.stallF;
  assign hs.stallE     = stall_e;
  assign hs.stallM     = hs.mem_stallM;
  assign hs.stallW     = 1'b0;
  assign hs.flushF     = 1'b0;
  assign hs.flushD     = exc_fire | ((hs.flush_predM | hs.flush_jumpE) & ~hs.mem_stallM);
  assign hs.flushE     = exc_fire | (~hs.mem_stallM & ~h_e & (hs.flush_predM | lu_stall));
  assign hs.flushM     = exc_fire | (h_e & ~hs.mem_stallM);
  assign hs.flushW     = hs.mem_stallM;
  assign hs.forward_aE = sel_a;
  assign hs.forward_bE = sel_b;
  assign hs.div_busy   = (state == BUSY);
  assign hs.div_done   = (state == DONE);
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int NF = 2;
  localparam int AW = 5;
  localparam int DC = 4;
  localparam int FW = $clog2(NF + 1);

  typedef struct packed {
    logic [AW-1:0]    rsD, rtD;
    logic             use_rsD, use_rtD;
    logic [AW-1:0]    rsE, rtE;
    logic             load_E, reg_write_enE;
    logic [AW-1:0]    reg_writeE;
    logic             div_startE;
    logic [NF-1:0]    fwd_we;
    logic [NF*AW-1:0] fwd_addr;
    logic [NF-1:0]    fwd_ready;
    logic             mem_stallM, flush_jumpE, flush_predM, flush_excM;
  } in_t;

  // stall/flush bit order: [4]=F [3]=D [2]=E [1]=M [0]=W
  typedef struct packed {
    logic [4:0]    stall;
    logic [4:0]    flush;
    logic [FW-1:0] fa, fb;
    logic          busy, done;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_FWD(NF), .REG_AW(AW)) bus ();
  hazard_scoreboard #(.NUM_FWD(NF), .REG_AW(AW), .DIV_CYCLES(DC)) dut (
    .clk(clk), .resetn(resetn), .hs(bus.slave));

  int checks = 0, failures = 0;

  // Reference state: cycles of divide occupancy still owed, result-held flag, pending exception.
  int   m_left;
  logic m_done, m_pend;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(in_t v);
    bus.rsD = v.rsD; bus.rtD = v.rtD; bus.use_rsD = v.use_rsD; bus.use_rtD = v.use_rtD;
    bus.rsE = v.rsE; bus.rtE = v.rtE; bus.load_E = v.load_E; bus.reg_write_enE = v.reg_write_enE;
    bus.reg_writeE = v.reg_writeE; bus.div_startE = v.div_startE;
    bus.fwd_we = v.fwd_we; bus.fwd_addr = v.fwd_addr; bus.fwd_ready = v.fwd_ready;
    bus.mem_stallM = v.mem_stallM; bus.flush_jumpE = v.flush_jumpE;
    bus.flush_predM = v.flush_predM; bus.flush_excM = v.flush_excM;
  endtask

  function automatic out_t act_out();
    out_t o;
    o.stall = {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW};
    o.flush = {bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW};
    o.fa = bus.forward_aE; o.fb = bus.forward_bE;
    o.busy = bus.div_busy; o.done = bus.div_done;
    return o;
  endfunction

  function automatic out_t model_out(input in_t v, output logic start_o);
    out_t o;
    logic req, fire, ds, lu, idle, he, mem;
    int fa, fb;
    o = '0; mem = v.mem_stallM;
    req = v.flush_excM | m_pend;
    fire = req & ~mem;
    fa = 0; fb = 0;
    for (int k = 0; k < NF; k++) begin
      if (fa == 0 && v.fwd_we[k] && v.fwd_addr[k*AW +: AW] == v.rsE && v.rsE != 0) fa = k + 1;
      if (fb == 0 && v.fwd_we[k] && v.fwd_addr[k*AW +: AW] == v.rtE && v.rtE != 0) fb = k + 1;
    end
    ds = 1'b0;
    if (fa != 0 && !v.fwd_ready[fa-1]) ds = 1'b1;
    if (fb != 0 && !v.fwd_ready[fb-1]) ds = 1'b1;
    lu = v.load_E && v.reg_write_enE && v.reg_writeE != 0 &&
         ((v.use_rsD && v.rsD == v.reg_writeE) || (v.use_rtD && v.rtD == v.reg_writeE));
    idle = (m_left == 0) && !m_done;
    start_o = idle && v.div_startE && !fire && !mem && !ds;
    he = start_o || (m_left > 0) || ds;
    o.stall[4] = !fire && (mem || he || lu);
    o.stall[3] = o.stall[4];
    o.stall[2] = !fire && (mem || he);
    o.stall[1] = mem;
    o.flush[3] = fire || ((v.flush_predM || v.flush_jumpE) && !mem);
    o.flush[2] = fire || (!mem && !he && (v.flush_predM || lu));
    o.flush[1] = fire || (he && !mem);
    o.flush[0] = mem;
    o.fa = FW'(fa); o.fb = FW'(fb);
    o.busy = (m_left > 0); o.done = m_done;
    return o;
  endfunction

  task automatic model_tick(in_t v);
    out_t o; logic st, fire;
    o = model_out(v, st);
    fire = (v.flush_excM | m_pend) & ~v.mem_stallM;
    if (fire) begin m_left = 0; m_done = 1'b0; end
    else if (st) m_left = DC - 1;
    else if (m_left > 0) begin m_left--; if (m_left == 0) m_done = 1'b1; end
    else if (m_done && !o.stall[2]) m_done = 1'b0;
    m_pend = (v.flush_excM | m_pend) & v.mem_stallM;
  endtask

  task automatic do_reset();
    in_t z; z = '0;
    @(negedge clk);
    apply(z); resetn = 1'b0;
    m_left = 0; m_done = 1'b0; m_pend = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic add(in_t v, logic [4:0] st, logic [4:0] fl, logic [FW-1:0] fa, logic [FW-1:0] fb);
    vec_t e;
    e.i = v; e.o.stall = st; e.o.flush = fl; e.o.fa = fa; e.o.fb = fb;
    e.o.busy = 1'b0; e.o.done = 1'b0;
    tbl.push_back(e);
  endtask

  initial begin
    in_t v;
    out_t e;
    logic st;
    // table of combinational cases, state stays IDLE throughout
    v = '0;                                                                   add(v, 5'b00000, 5'b00000, 0, 0);
    v = '0; v.fwd_we = 2'b11; v.fwd_addr = {5'd5, 5'd5}; v.rsE = 5; v.fwd_ready = 2'b11;
                                                                              add(v, 5'b00000, 5'b00000, 1, 0);
    v = '0; v.fwd_we = 2'b11; v.fwd_addr = {5'd5, 5'd4}; v.rsE = 5; v.rtE = 4; v.fwd_ready = 2'b11;
                                                                              add(v, 5'b00000, 5'b00000, 2, 1);
    v = '0; v.fwd_we = 2'b01; v.fwd_ready = 2'b11;                            add(v, 5'b00000, 5'b00000, 0, 0);
    v = '0; v.fwd_we = 2'b01; v.fwd_addr = {5'd0, 5'd7}; v.rsE = 7;           add(v, 5'b11100, 5'b00010, 1, 0);
    v.fwd_ready = 2'b01;                                                      add(v, 5'b00000, 5'b00000, 1, 0);
    v = '0; v.fwd_we = 2'b10; v.fwd_addr = {5'd9, 5'd0}; v.rtE = 9; v.fwd_ready = 2'b01;
                                                                              add(v, 5'b11100, 5'b00010, 0, 2);
    v = '0; v.load_E = 1; v.reg_write_enE = 1; v.reg_writeE = 3; v.use_rtD = 1; v.rtD = 3;
                                                                              add(v, 5'b11000, 5'b00100, 0, 0);
    v.reg_writeE = 0; v.rtD = 0;                                              add(v, 5'b00000, 5'b00000, 0, 0);
    v = '0; v.load_E = 1; v.reg_write_enE = 1; v.reg_writeE = 3; v.rsD = 3; v.use_rtD = 1; v.rtD = 1;
                                                                              add(v, 5'b00000, 5'b00000, 0, 0);
    v = '0; v.mem_stallM = 1;                                                 add(v, 5'b11110, 5'b00001, 0, 0);
    v = '0; v.flush_predM = 1;                                                add(v, 5'b00000, 5'b01100, 0, 0);
    v = '0; v.flush_jumpE = 1;                                                add(v, 5'b00000, 5'b01000, 0, 0);
    v = '0; v.flush_predM = 1; v.mem_stallM = 1;                              add(v, 5'b11110, 5'b00001, 0, 0);
    v = '0; v.flush_excM = 1;                                                 add(v, 5'b00000, 5'b01110, 0, 0);
    v = '0; v.flush_predM = 1; v.load_E = 1; v.reg_write_enE = 1; v.reg_writeE = 6; v.use_rsD = 1; v.rsD = 6;
                                                                              add(v, 5'b11000, 5'b01100, 0, 0);

    // reset state
    v = '0; apply(v); resetn = 1'b0;
    #1 chk("reset_outputs", 32'(act_out()), 32'd0);
    do_reset();
    chk("post_reset_outputs", 32'(act_out()), 32'd0);

    foreach (tbl[n]) begin
      apply(tbl[n].i);
      #1 chk($sformatf("vec%0d", n), 32'(act_out()), 32'(tbl[n].o));
      @(negedge clk);
    end

    // divide: start at cycle 0, instruction stays in E through DONE
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      v = '0; v.div_startE = (c <= 4);
      apply(v);
      #1;
      chk($sformatf("div_stallE_c%0d", c), 32'(bus.stallE), 32'(c <= 3));
      chk($sformatf("div_busy_c%0d", c), 32'(bus.div_busy), 32'(c >= 1 && c <= 3));
      chk($sformatf("div_done_c%0d", c), 32'(bus.div_done), 32'(c == 4));
      @(negedge clk);
    end

    // exception pulse while memory is stalled
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      v = '0; v.mem_stallM = (c < 3); v.flush_excM = (c == 0);
      apply(v);
      #1;
      chk($sformatf("excmem_flushDEM_c%0d", c), 32'({bus.flushD, bus.flushE, bus.flushM}),
          (c == 3) ? 32'd7 : 32'd0);
      if (c == 3)
        chk("excmem_stalls_fire", 32'({bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW}), 32'd0);
      @(negedge clk);
    end

    // exception in cycle 2 of a divide
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      v = '0; v.div_startE = (c <= 2); v.flush_excM = (c == 2);
      apply(v);
      #1;
      if (c == 2) begin
        chk("excdiv_flushDEM", 32'({bus.flushD, bus.flushE, bus.flushM}), 32'd7);
        chk("excdiv_stallE", 32'(bus.stallE), 32'd0);
      end
      if (c == 3) begin
        chk("excdiv_busy_after", 32'(bus.div_busy), 32'd0);
        chk("excdiv_stallE_after", 32'(bus.stallE), 32'd0);
      end
      @(negedge clk);
    end

    // asynchronous reset mid-divide
    do_reset();
    v = '0; v.div_startE = 1'b1;
    apply(v);
    repeat (2) @(negedge clk);
    #1 chk("arst_busy_before", 32'(bus.div_busy), 32'd1);
    v.div_startE = 1'b0; apply(v); resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.div_busy), 32'd0);
    chk("arst_stallE", 32'(bus.stallE), 32'd0);

    // randomized against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      v.rsD = AW'($urandom_range(0, 3)); v.rtD = AW'($urandom_range(0, 3));
      v.use_rsD = 1'($urandom); v.use_rtD = 1'($urandom);
      v.rsE = AW'($urandom_range(0, 3)); v.rtE = AW'($urandom_range(0, 3));
      v.load_E = 1'($urandom); v.reg_write_enE = 1'($urandom);
      v.reg_writeE = AW'($urandom_range(0, 3));
      v.div_startE = ($urandom_range(0, 5) == 0);
      v.fwd_we = NF'($urandom);
      for (int k = 0; k < NF; k++) begin
        v.fwd_addr[k*AW +: AW] = AW'($urandom_range(0, 3));
        v.fwd_ready[k] = ($urandom_range(0, 3) != 0);
      end
      v.mem_stallM = ($urandom_range(0, 4) == 0);
      v.flush_jumpE = ($urandom_range(0, 7) == 0);
      v.flush_predM = ($urandom_range(0, 7) == 0);
      v.flush_excM = ($urandom_range(0, 15) == 0);
      apply(v);
      #1;
      e = model_out(v, st);
      chk($sformatf("rand_c%0d", c), 32'(act_out()), 32'(e));
      @(posedge clk);
      model_tick(v);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
